// File: rtl/pq_sr_param_pkg.sv
// Shared priority-queue types: queue ordering mode, per-cycle operation and a
// width-generic key priority compare.
package pq_sr_param_pkg;

  typedef enum logic {
    MIN_PQ = 1'b0,
    MAX_PQ = 1'b1
  } pq_type_t;

  typedef enum logic [1:0] {
    PQ_NOP  = 2'd0,
    PQ_ENQ  = 2'd1,
    PQ_DEQ  = 2'd2,
    PQ_REPL = 2'd3
  } pq_op_t;

  localparam int unsigned KeyW = 8;
  localparam int unsigned ValW = 8;

  typedef struct packed {
    logic [KeyW-1:0] key;
    logic [ValW-1:0] val;
  } kv_t;

  // Keys are zero-extended into this width, so any KEY_WIDTH up to it compares unsigned.
  localparam int unsigned PqMaxKeyW = 64;

  // True when key a has strictly higher priority than key b.
  function automatic logic pq_beats(input pq_type_t pq_type,
                                    input logic [PqMaxKeyW-1:0] a,
                                    input logic [PqMaxKeyW-1:0] b);
    return (pq_type == MIN_PQ) ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/pq_sr_param_cell.sv
// One slot of the shift-register priority queue: holds, shifts left/right or
// captures the new entry depending on the op and the insertion flags.
module pq_sr_param_cell
  import pq_sr_param_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = 8,
  parameter int unsigned VAL_WIDTH = 8,
  parameter pq_type_t    PQ_TYPE   = MIN_PQ
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  pq_op_t               op,
  input  logic                 ins_flag,
  input  logic                 ins_flag_left,
  input  logic                 left_valid,
  input  logic [KEY_WIDTH-1:0] left_key,
  input  logic [VAL_WIDTH-1:0] left_val,
  input  logic                 right_valid,
  input  logic [KEY_WIDTH-1:0] right_key,
  input  logic [VAL_WIDTH-1:0] right_val,
  input  logic [KEY_WIDTH-1:0] new_key,
  input  logic [VAL_WIDTH-1:0] new_val,
  output logic                 beats,
  output logic                 valid,
  output logic [KEY_WIDTH-1:0] key,
  output logic [VAL_WIDTH-1:0] val
);

  logic                 valid_q, valid_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [VAL_WIDTH-1:0] val_q, val_d;
  logic [PqMaxKeyW-1:0] new_ext, own_ext;

  // Strict compare keeps FIFO order among equal keys; an empty slot is always beaten.
  always_comb begin
    new_ext = '0;
    own_ext = '0;
    new_ext[KEY_WIDTH-1:0] = new_key;
    own_ext[KEY_WIDTH-1:0] = key_q;
    beats = !valid_q || pq_beats(PQ_TYPE, new_ext, own_ext);
  end

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    val_d   = val_q;
    unique case (op)
      PQ_ENQ: begin
        if (ins_flag) begin
          if (ins_flag_left) begin
            valid_d = left_valid;
            key_d   = left_key;
            val_d   = left_val;
          end else begin
            valid_d = 1'b1;
            key_d   = new_key;
            val_d   = new_val;
          end
        end
      end
      PQ_DEQ: begin
        valid_d = right_valid;
        key_d   = right_key;
        val_d   = right_val;
      end
      // Contents left of the insertion point shift left; right of it stay in place.
      PQ_REPL: begin
        if (ins_flag) begin
          if (!ins_flag_left) begin
            valid_d = 1'b1;
            key_d   = new_key;
            val_d   = new_val;
          end
        end else begin
          valid_d = right_valid;
          key_d   = right_key;
          val_d   = right_val;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      key_q   <= '0;
      val_q   <= '0;
    end else begin
      valid_q <= valid_d;
      key_q   <= key_d;
      val_q   <= val_d;
    end
  end

  assign valid = valid_q;
  assign key   = key_q;
  assign val   = val_q;

endmodule

// File: rtl/pq_sr_param.sv
// Parametrised shift-register priority queue: DEPTH sorted slots with the
// highest-priority entry at slot 0, single-cycle enqueue/dequeue/replace.
module pq_sr_param
  import pq_sr_param_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = 8,
  parameter int unsigned VAL_WIDTH = 8,
  parameter int unsigned DEPTH     = 8,
  parameter pq_type_t    PQ_TYPE   = MIN_PQ,
  localparam int unsigned CntW     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enq,
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic [VAL_WIDTH-1:0] val_i,
  input  logic                 deq,
  output logic [KEY_WIDTH-1:0] key_o,
  output logic [VAL_WIDTH-1:0] val_o,
  output logic                 valid_o,
  output logic                 full,
  output logic                 empty,
  output logic [CntW-1:0]      count,
  output logic                 ovf_err,
  output logic                 udf_err
);

  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  pq_op_t                op;
  logic [CntW-1:0]       count_q, count_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  full_q, empty_q;

  logic [DEPTH-1:0]      beats;
  logic [DEPTH:0]        beats_ext;
  logic [DEPTH-1:0]      ins_flag, ins_flag_left;
  logic                  slot_valid [DEPTH];
  logic [KEY_WIDTH-1:0]  slot_key   [DEPTH];
  logic [VAL_WIDTH-1:0]  slot_val   [DEPTH];
  logic                  pad_valid  [DEPTH+2];
  logic [KEY_WIDTH-1:0]  pad_key    [DEPTH+2];
  logic [VAL_WIDTH-1:0]  pad_val    [DEPTH+2];

  assign full_q  = (count_q == DepthC);
  assign empty_q = (count_q == '0);

  // Request decode; illegal requests collapse to NOP (or ENQ for replace-on-empty).
  always_comb begin
    op      = PQ_NOP;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    count_d = count_q;
    unique case ({enq, deq})
      2'b10: begin
        if (full_q) begin
          ovf_d = 1'b1;
        end else begin
          op      = PQ_ENQ;
          count_d = count_q + CntW'(1);
        end
      end
      2'b01: begin
        if (empty_q) begin
          udf_d = 1'b1;
        end else begin
          op      = PQ_DEQ;
          count_d = count_q - CntW'(1);
        end
      end
      2'b11: begin
        if (empty_q) begin
          op      = PQ_ENQ;
          udf_d   = 1'b1;
          count_d = count_q + CntW'(1);
        end else begin
          op = PQ_REPL;
        end
      end
      default: ;
    endcase
  end

  // Insertion chains: for replace, slot i compares against what will shift into it (slot i+1).
  assign beats_ext = {1'b1, beats};

  always_comb begin
    logic enq_chain, repl_chain, prev;
    enq_chain     = 1'b0;
    repl_chain    = 1'b0;
    prev          = 1'b0;
    ins_flag      = '0;
    ins_flag_left = '0;
    for (int i = 0; i < DEPTH; i++) begin
      enq_chain        = enq_chain | beats_ext[i];
      repl_chain       = repl_chain | beats_ext[i+1];
      ins_flag_left[i] = prev;
      ins_flag[i]      = (op == PQ_REPL) ? repl_chain : enq_chain;
      prev             = ins_flag[i];
    end
  end

  always_comb begin
    pad_valid[0]       = 1'b0;
    pad_key[0]         = '0;
    pad_val[0]         = '0;
    pad_valid[DEPTH+1] = 1'b0;
    pad_key[DEPTH+1]   = '0;
    pad_val[DEPTH+1]   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pad_valid[i+1] = slot_valid[i];
      pad_key[i+1]   = slot_key[i];
      pad_val[i+1]   = slot_val[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : gen_cell
    pq_sr_param_cell #(
      .KEY_WIDTH(KEY_WIDTH),
      .VAL_WIDTH(VAL_WIDTH),
      .PQ_TYPE  (PQ_TYPE)
    ) u_cell (
      .clk          (clk),
      .rst_n        (rst_n),
      .op           (op),
      .ins_flag     (ins_flag[g]),
      .ins_flag_left(ins_flag_left[g]),
      .left_valid   (pad_valid[g]),
      .left_key     (pad_key[g]),
      .left_val     (pad_val[g]),
      .right_valid  (pad_valid[g+2]),
      .right_key    (pad_key[g+2]),
      .right_val    (pad_val[g+2]),
      .new_key      (key_i),
      .new_val      (val_i),
      .beats        (beats[g]),
      .valid        (slot_valid[g]),
      .key          (slot_key[g]),
      .val          (slot_val[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign key_o   = slot_key[0];
  assign val_o   = slot_val[0];
  assign valid_o = slot_valid[0];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;

endmodule

// File: tb/tb_pq_sr_param.sv
// Bench for pq_sr_param: MIN and MAX instances (DEPTH=4) driven in lockstep and
// compared against a sorted-array reference model, directed then random.
module tb_pq_sr_param;
  import pq_sr_param_pkg::*;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       enq;
  logic       deq;
  logic [7:0] key_i;
  logic [7:0] val_i;

  logic [7:0] k_min, v_min, k_max, v_max;
  logic       vld_min, full_min, empty_min, ovf_min, udf_min;
  logic       vld_max, full_max, empty_max, ovf_max, udf_max;
  logic [2:0] cnt_min, cnt_max;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: per mode, a sorted array of {key,val} plus occupancy.
  logic [15:0] mq0 [DEPTH];
  logic [15:0] mq1 [DEPTH];
  int          msz [2];
  bit          exp_ovf [2];
  bit          exp_udf [2];

  pq_sr_param #(
    .KEY_WIDTH(8), .VAL_WIDTH(8), .DEPTH(DEPTH), .PQ_TYPE(MIN_PQ)
  ) u_min (
    .clk(clk), .rst_n(rst_n), .enq(enq), .key_i(key_i), .val_i(val_i), .deq(deq),
    .key_o(k_min), .val_o(v_min), .valid_o(vld_min), .full(full_min), .empty(empty_min),
    .count(cnt_min), .ovf_err(ovf_min), .udf_err(udf_min)
  );

  pq_sr_param #(
    .KEY_WIDTH(8), .VAL_WIDTH(8), .DEPTH(DEPTH), .PQ_TYPE(MAX_PQ)
  ) u_max (
    .clk(clk), .rst_n(rst_n), .enq(enq), .key_i(key_i), .val_i(val_i), .deq(deq),
    .key_o(k_max), .val_o(v_max), .valid_o(vld_max), .full(full_max), .empty(empty_max),
    .count(cnt_max), .ovf_err(ovf_max), .udf_err(udf_max)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] mget(input int m, input int i);
    return (m == 0) ? mq0[i] : mq1[i];
  endfunction

  task automatic mset(input int m, input int i, input logic [15:0] x);
    if (m == 0) mq0[i] = x;
    else mq1[i] = x;
  endtask

  // First position whose entry the new key strictly beats; otherwise the tail.
  function automatic int ins_pos(input int m, input logic [7:0] k);
    for (int i = 0; i < msz[m]; i++) begin
      logic [15:0] e;
      e = mget(m, i);
      if ((m == 1) ? (k > e[15:8]) : (k < e[15:8])) return i;
    end
    return msz[m];
  endfunction

  task automatic m_pop(input int m);
    for (int i = 0; i < msz[m] - 1; i++) mset(m, i, mget(m, i + 1));
    msz[m]--;
  endtask

  task automatic m_push(input int m, input logic [7:0] k, input logic [7:0] v);
    int p;
    p = ins_pos(m, k);
    for (int i = msz[m] - 1; i >= p; i--) mset(m, i + 1, mget(m, i));
    mset(m, p, {k, v});
    msz[m]++;
  endtask

  task automatic model_op(input int m, input bit e, input bit d, input logic [7:0] k,
                          input logic [7:0] v);
    exp_ovf[m] = 1'b0;
    exp_udf[m] = 1'b0;
    if (e && d) begin
      if (msz[m] == 0) exp_udf[m] = 1'b1;
      else m_pop(m);
      m_push(m, k, v);
    end else if (e) begin
      if (msz[m] == DEPTH) exp_ovf[m] = 1'b1;
      else m_push(m, k, v);
    end else if (d) begin
      if (msz[m] == 0) exp_udf[m] = 1'b1;
      else m_pop(m);
    end
  endtask

  task automatic check_one(input string nm, input int m, input logic [7:0] k,
                           input logic [7:0] v, input logic vld, input logic f,
                           input logic em, input logic [2:0] c, input logic ovf,
                           input logic udf);
    logic [15:0] head;
    head = (msz[m] > 0) ? mget(m, 0) : 16'h0000;
    chk({nm, ".key"}, k, head[15:8]);
    chk({nm, ".val"}, v, head[7:0]);
    chk({nm, ".valid"}, vld, msz[m] > 0);
    chk({nm, ".full"}, f, msz[m] == DEPTH);
    chk({nm, ".empty"}, em, msz[m] == 0);
    chk({nm, ".count"}, c, msz[m]);
    chk({nm, ".ovf"}, ovf, exp_ovf[m]);
    chk({nm, ".udf"}, udf, exp_udf[m]);
  endtask

  task automatic check_all();
    check_one("min", 0, k_min, v_min, vld_min, full_min, empty_min, cnt_min, ovf_min, udf_min);
    check_one("max", 1, k_max, v_max, vld_max, full_max, empty_max, cnt_max, ovf_max, udf_max);
  endtask

  task automatic step(input bit e, input bit d, input logic [7:0] k, input logic [7:0] v);
    enq   = e;
    deq   = d;
    key_i = k;
    val_i = v;
    @(posedge clk);
    #1;
    enq = 1'b0;
    deq = 1'b0;
    model_op(0, e, d, k, v);
    model_op(1, e, d, k, v);
    check_all();
  endtask

  task automatic reset_cycle(input bit hold_enq);
    rst_n = 1'b0;
    enq   = hold_enq;
    key_i = 8'($urandom);
    val_i = 8'($urandom);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    enq   = 1'b0;
    for (int m = 0; m < 2; m++) begin
      msz[m]     = 0;
      exp_ovf[m] = 1'b0;
      exp_udf[m] = 1'b0;
    end
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    enq   = 1'b0;
    deq   = 1'b0;
    key_i = '0;
    val_i = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mq0[i] = '0;
      mq1[i] = '0;
    end
    @(posedge clk);
    #1;
    reset_cycle(1'b0);

    // Idle, then dequeues on an empty queue.
    step(1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    chk("min.udf_first", udf_min, 1'b1);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    chk("min.udf_second", udf_min, 1'b1);
    chk("min.cnt_after_udf", cnt_min, 3'd0);

    // Equal keys keep FIFO order.
    step(1'b1, 1'b0, 8'd5, 8'd1);
    step(1'b1, 1'b0, 8'd2, 8'd2);
    step(1'b1, 1'b0, 8'd9, 8'd3);
    step(1'b1, 1'b0, 8'd2, 8'd4);
    chk("min.fifo_head", {k_min, v_min}, {8'd2, 8'd2});
    chk("min.fifo_full", full_min, 1'b1);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    chk("min.fifo_deq1", {k_min, v_min}, {8'd2, 8'd4});
    step(1'b0, 1'b1, 8'h00, 8'h00);
    chk("min.fifo_deq2", {k_min, v_min}, {8'd5, 8'd1});
    step(1'b0, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    chk("min.fifo_empty", empty_min, 1'b1);

    // Overflow on full, then replace while full.
    reset_cycle(1'b0);
    step(1'b1, 1'b0, 8'd1, 8'd10);
    step(1'b1, 1'b0, 8'd3, 8'd11);
    step(1'b1, 1'b0, 8'd5, 8'd12);
    step(1'b1, 1'b0, 8'd7, 8'd13);
    step(1'b1, 1'b0, 8'd0, 8'd14);
    chk("min.ovf", ovf_min, 1'b1);
    chk("min.ovf_head", k_min, 8'd1);
    step(1'b1, 1'b1, 8'd4, 8'd15);
    chk("min.repl_head", k_min, 8'd3);
    chk("min.repl_cnt", cnt_min, 3'd4);
    chk("min.repl_no_ovf", ovf_min, 1'b0);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    chk("min.repl_second", {k_min, v_min}, {8'd4, 8'd15});
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 8'h00);

    // Extreme keys.
    reset_cycle(1'b0);
    step(1'b1, 1'b0, 8'h00, 8'h21);
    step(1'b1, 1'b0, 8'hFF, 8'h22);
    step(1'b1, 1'b0, 8'h80, 8'h23);
    chk("max.extreme_head", k_max, 8'hFF);
    chk("min.extreme_head", k_min, 8'h00);

    // Replace on an empty queue acts as enqueue with underflow flagged.
    reset_cycle(1'b0);
    step(1'b1, 1'b1, 8'd6, 8'd7);
    chk("min.repl_empty_head", k_min, 8'd6);
    chk("max.repl_empty_udf", udf_max, 1'b1);

    // Reset beats a concurrent enqueue.
    reset_cycle(1'b0);
    step(1'b1, 1'b0, 8'd3, 8'd1);
    step(1'b1, 1'b0, 8'd8, 8'd2);
    step(1'b1, 1'b0, 8'd1, 8'd3);
    reset_cycle(1'b1);
    chk("min.rst_enq_empty", empty_min, 1'b1);

    // Random traffic with small key range to exercise equal keys.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset_cycle(1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
             ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)),
             8'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pq_sr_param.md
# pq_sr_param

Parametrised shift-register hardware priority queue: a sorted array of DEPTH <key,value> slots with the highest-priority entry always at the head, supporting single-cycle enqueue, dequeue and replace (simultaneous dequeue+enqueue). It generalises the shared PQ definitions with per-instance key/value width, depth and MIN/MAX mode. Per-slot valid bits remove the sentinel-key restriction. It is the drop-in HWPQ building block that benches and the HWPQ comparison study instantiate directly.

## Interface
- KEY_WIDTH, 8, key width in bits
- VAL_WIDTH, 8, value width in bits
- DEPTH, 8, number of slots (≥2)
- PQ_TYPE, MIN_PQ, pq_type_t; MIN_PQ means a smaller key is higher priority
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- enq  in  1  enqueue request
- key_i  in  KEY_WIDTH  key to enqueue
- val_i  in  VAL_WIDTH  value to enqueue
- deq  in  1  dequeue request; removes the head
- key_o  out  KEY_WIDTH  head key, registered
- val_o  out  VAL_WIDTH  head value, registered
- valid_o  out  1  head is valid (equals !empty)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH+1)  number of stored entries
- ovf_err  out  1  one-cycle pulse: enq dropped because the queue was full
- udf_err  out  1  one-cycle pulse: deq ignored because the queue was empty

## Operation
- Storage: slot[0..DEPTH-1], each holding {valid, key, value}. Valid slots are contiguous from slot 0 and sorted; slot 0 is the head.
- Priority: "a beats b" means a.key < b.key for MIN_PQ, and a.key > b.key for MAX_PQ. Equal keys keep FIFO order, so a new entry goes behind existing equal keys.
- Ops are decoded each cycle from {enq, deq} as pq_op_t:
  - NOP: state is held.
  - ENQ (not full): insert at the lowest index i where the new entry beats slot[i], or slot[i] is invalid. Slots i.. shift right by one. count+1.
  - ENQ when full: entry dropped, state held, ovf_err=1.
  - DEQ (not empty): all slots shift left by one. Slot[DEPTH-1] becomes invalid. count−1.
  - DEQ when empty: state held, udf_err=1.
  - REPL with both requested, not empty: the head is removed and the new entry is inserted into the remaining slot[1..] contents in the same cycle. count is unchanged. Legal when full, with no ovf_err.
  - Both requested while empty: performed as ENQ, and udf_err=1.
- Keys and values have no reserved encodings; every key value is legal.
- Invalid slots drive key/value = 0. key_o/val_o read 0 while empty.

## Timing
- All outputs are registered from slot state. No combinational path from any input to any output.
- Latency: the result of an operation at edge N is visible on key_o/val_o/count/flags after edge N. Back-to-back ops every cycle are allowed.
- ovf_err/udf_err assert in the cycle after the offending request edge, for exactly one cycle.
- Reset (rst_n=0 at an edge): all slots invalid and zeroed, count=0, empty=1, full=0, valid_o=0, key_o=val_o=0, ovf_err=udf_err=0.
- Reset has priority over enq/deq in the same cycle. Reset mid-stream discards all contents.
- No internal FSM beyond the slot array and count register. count saturates logically at 0 and DEPTH, never wraps.

## Structure
- Shared pq_pkg gets:
  - the pq_op_t enum {PQ_NOP, PQ_ENQ, PQ_DEQ, PQ_REPL};
  - a width-generic priority compare, a function parameterised by PQ_TYPE that takes raw key vectors.
  - The existing pq_type_t and MIN_PQ/MAX_PQ are reused. The default-width kv_t is unchanged.
- Sub-module pq_sr_cell: one slot. Its inputs are:
  - the left and right neighbour contents;
  - the new entry;
  - the op;
  - an "insert here or left" flag, formed from its own compare and the left neighbour's flag.
  
  The top generates DEPTH cells plus count/flag logic.

## Test plan
Run every scenario below with DEPTH=4 and 8-bit keys/values, in both modes.
- Reset, then idle: empty=1, count=0, key_o=0. Two deq requests give udf_err on each cycle following them, and count stays 0.
- MIN mode, enqueue keys 5,2,9,2 (values 1,2,3,4):
  - head is key 2/val 2, full=1;
  - successive deqs return (2,2),(2,4),(5,1),(9,3), then empty=1.
- MIN mode full {1,3,5,7}, enq key 0: ovf_err=1, contents unchanged. Replace with key 4: head becomes 3, order {3,4,5,7}, count=4, no ovf_err.
- MAX mode, enqueue keys 0x00,0xFF,0x80: head 0xFF. This confirms the extreme keys are legal.
- Both enq and deq on an empty queue with key 6: head becomes 6, count=1, udf_err=1.
- Assert rst_n=0 after three enqueues with enq held high: the next cycle shows empty=1, count=0 and no entry inserted.
